// File: rtl/perf_memsys_pkg.sv
// Shared constants and types for the memory-system performance counter reader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package perf_memsys_pkg;

  localparam int NUM_CTRS = 15;
  localparam int BEATS    = 2 * NUM_CTRS;   // one lo and one hi word per counter
  localparam int BEAT_W   = $clog2(BEATS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Counter index as carried on rsp_idx, in interface declaration order.
  typedef enum logic [3:0] {
    CTR_ICACHE_READS        = 4'd0,
    CTR_ICACHE_READ_MISSES  = 4'd1,
    CTR_DCACHE_READS        = 4'd2,
    CTR_DCACHE_WRITES       = 4'd3,
    CTR_DCACHE_READ_MISSES  = 4'd4,
    CTR_DCACHE_WRITE_MISSES = 4'd5,
    CTR_DCACHE_BANK_STALLS  = 4'd6,
    CTR_DCACHE_MSHR_STALLS  = 4'd7,
    CTR_SMEM_READS          = 4'd8,
    CTR_SMEM_WRITES         = 4'd9,
    CTR_SMEM_BANK_STALLS    = 4'd10,
    CTR_MEM_READS           = 4'd11,
    CTR_MEM_WRITES          = 4'd12,
    CTR_MEM_LATENCY         = 4'd13,
    CTR_SAME_ACCESS         = 4'd14
  } ctr_idx_t;

endpackage

// File: rtl/VX_perf_memsys_if.sv
// Bundle of the 15 live memory-system performance counters, CTR_W bits each.
// Latency: n/a (wires only).
// Backpressure: none; counters are free-running levels.
// Modports: master drives the counters, slave observes them.
interface VX_perf_memsys_if #(
  parameter int CTR_W = 44
) ();

  logic [CTR_W-1:0] icache_reads;
  logic [CTR_W-1:0] icache_read_misses;
  logic [CTR_W-1:0] dcache_reads;
  logic [CTR_W-1:0] dcache_writes;
  logic [CTR_W-1:0] dcache_read_misses;
  logic [CTR_W-1:0] dcache_write_misses;
  logic [CTR_W-1:0] dcache_bank_stalls;
  logic [CTR_W-1:0] dcache_mshr_stalls;
  logic [CTR_W-1:0] smem_reads;
  logic [CTR_W-1:0] smem_writes;
  logic [CTR_W-1:0] smem_bank_stalls;
  logic [CTR_W-1:0] mem_reads;
  logic [CTR_W-1:0] mem_writes;
  logic [CTR_W-1:0] mem_latency;
  logic [CTR_W-1:0] same_access;

  modport master (
    output icache_reads, icache_read_misses, dcache_reads, dcache_writes,
           dcache_read_misses, dcache_write_misses, dcache_bank_stalls,
           dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls,
           mem_reads, mem_writes, mem_latency, same_access
  );

  modport slave (
    input  icache_reads, icache_read_misses, dcache_reads, dcache_writes,
           dcache_read_misses, dcache_write_misses, dcache_bank_stalls,
           dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls,
           mem_reads, mem_writes, mem_latency, same_access
  );

endinterface

// File: rtl/perf_memsys_reader.sv
// Snapshots 15 memory-system counters atomically and streams them as 30 x 32-bit beats.
// Latency: first beat valid 1 cycle after snap_valid&snap_ready; next snapshot 1 cycle after last beat.
// Backpressure: beat held stable while rsp_valid&!rsp_ready; snap_ready low while streaming.
//
// Ports: clk / reset (async, active-high); perf_memsys_if (live counters, slave);
//        snap_valid/snap_ready (snapshot request); rsp_valid/rsp_ready/rsp_data/
//        rsp_idx/rsp_hi/rsp_last (beat stream); busy (streaming in progress).
// Build option: define PERF_DELTA_EN to stream (live - previous snapshot) mod 2^CTR_W
//               instead of absolute counter values.
module perf_memsys_reader
  import perf_memsys_pkg::*;
#(
  parameter int CTR_W = 44,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  VX_perf_memsys_if.slave  perf_memsys_if,
  input  logic             snap_valid,
  output logic             snap_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic [3:0]       rsp_idx,
  output logic             rsp_hi,
  output logic             rsp_last,
  output logic             busy
);

  typedef logic [NUM_CTRS-1:0][CTR_W-1:0] ctr_vec_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  ctr_vec_t          live;
  ctr_vec_t          latch_val;
  ctr_vec_t          snap_q;
  logic              accept;
  logic              beat_fire;
  logic              last_beat;

  // Even beats carry bits [31:0], odd beats bits [CTR_W-1:32] zero-extended.
  function automatic logic [OUT_W-1:0] beat_word(input ctr_vec_t vec,
                                                 input logic [BEAT_W-1:0] beat);
    logic [63:0] wide;
    wide = 64'(vec[beat[BEAT_W-1:1]]);
    return beat[0] ? OUT_W'(wide[63:32]) : OUT_W'(wide[31:0]);
  endfunction

  // Element 0 is icache_reads, element 14 is same_access.
  assign live = {perf_memsys_if.same_access,        perf_memsys_if.mem_latency,
                 perf_memsys_if.mem_writes,         perf_memsys_if.mem_reads,
                 perf_memsys_if.smem_bank_stalls,   perf_memsys_if.smem_writes,
                 perf_memsys_if.smem_reads,         perf_memsys_if.dcache_mshr_stalls,
                 perf_memsys_if.dcache_bank_stalls, perf_memsys_if.dcache_write_misses,
                 perf_memsys_if.dcache_read_misses, perf_memsys_if.dcache_writes,
                 perf_memsys_if.dcache_reads,       perf_memsys_if.icache_read_misses,
                 perf_memsys_if.icache_reads};

  assign accept    = snap_valid & snap_ready;
  assign beat_fire = rsp_valid & rsp_ready;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

`ifdef PERF_DELTA_EN
  ctr_vec_t prev_q;

  // Subtraction wraps naturally at CTR_W bits.
  always_comb begin
    latch_val = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      latch_val[i] = live[i] - prev_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else if (accept) begin
      prev_q <= live;
    end
  end
`else
  assign latch_val = live;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_STREAM;
      ST_STREAM: if (beat_fire && last_beat) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs. snap_ready is gated by reset so it reads 0 while reset is held.
  always_comb begin
    snap_ready = (state_q == ST_IDLE) && !reset;
    busy       = (state_q == ST_STREAM);
    rsp_valid  = (state_q == ST_STREAM);
    rsp_last   = (state_q == ST_STREAM) && last_beat;
    rsp_data   = beat_word(snap_q, beat_q);
    rsp_idx    = beat_q[BEAT_W-1:1];
    rsp_hi     = beat_q[0];
  end

  // Snapshot registers and beat pointer; the pointer wraps to 0 on the last
  // handshake so idle outputs rest at idx 0 lo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q <= '0;
      snap_q <= '0;
    end else if (accept) begin
      beat_q <= '0;
      snap_q <= latch_val;
    end else if (beat_fire) begin
      beat_q <= last_beat ? '0 : beat_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_perf_memsys_reader.sv
module tb_perf_memsys_reader;
  import perf_memsys_pkg::*;

  localparam int          CTR_W = 44;
  localparam logic [63:0] MASK  = (64'd1 << CTR_W) - 64'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        snap_valid = 1'b0;
  logic        snap_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_idx;
  logic        rsp_hi;
  logic        rsp_last;
  logic        busy;

  VX_perf_memsys_if #(.CTR_W(CTR_W)) pm_if ();

  perf_memsys_reader #(.CTR_W(CTR_W), .OUT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .perf_memsys_if (pm_if),
    .snap_valid     (snap_valid),
    .snap_ready     (snap_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_idx        (rsp_idx),
    .rsp_hi         (rsp_hi),
    .rsp_last       (rsp_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic [3:0]  idx;
    logic        hi;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] live_v [NUM_CTRS];
  logic [63:0] prev_v [NUM_CTRS];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a snapshot is a list of 30 expected beats; the stream is
  // busy exactly while that list is non-empty.
  always @(posedge clk) begin : model
    beat_t       b;
    logic [63:0] v;
    if (reset) begin
      exp_q.delete();
      for (int c = 0; c < NUM_CTRS; c++) prev_v[c] = 64'd0;
    end else if (exp_q.size() != 0) begin
      if (rsp_ready) void'(exp_q.pop_front());
    end else if (snap_valid) begin
      for (int c = 0; c < NUM_CTRS; c++) begin
        v = (live_v[c] - prev_v[c]) & MASK;
        b.idx  = 4'(c);
        b.dat  = v[31:0];
        b.hi   = 1'b0;
        b.last = 1'b0;
        exp_q.push_back(b);
        b.dat  = v[63:32];
        b.hi   = 1'b1;
        b.last = (c == NUM_CTRS - 1);
        exp_q.push_back(b);
`ifdef PERF_DELTA_EN
        prev_v[c] = live_v[c];
`endif
      end
    end
  end

  // Compare process: checks every output on every falling edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_snap_ready", snap_ready, 0);
      chk("rst_rsp_valid",  rsp_valid,  0);
      chk("rst_busy",       busy,       0);
      chk("rst_rsp_last",   rsp_last,   0);
      chk("rst_rsp_data",   rsp_data,   0);
      chk("rst_rsp_idx",    rsp_idx,    0);
      chk("rst_rsp_hi",     rsp_hi,     0);
    end else if (exp_q.size() == 0) begin
      chk("idle_snap_ready", snap_ready, 1);
      chk("idle_rsp_valid",  rsp_valid,  0);
      chk("idle_busy",       busy,       0);
      chk("idle_rsp_last",   rsp_last,   0);
    end else begin
      chk("strm_snap_ready", snap_ready, 0);
      chk("strm_rsp_valid",  rsp_valid,  1);
      chk("strm_busy",       busy,       1);
      chk("strm_rsp_data",   rsp_data,   exp_q[0].dat);
      chk("strm_rsp_idx",    rsp_idx,    exp_q[0].idx);
      chk("strm_rsp_hi",     rsp_hi,     exp_q[0].hi);
      chk("strm_rsp_last",   rsp_last,   exp_q[0].last);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_if();
    pm_if.icache_reads        = live_v[0][CTR_W-1:0];
    pm_if.icache_read_misses  = live_v[1][CTR_W-1:0];
    pm_if.dcache_reads        = live_v[2][CTR_W-1:0];
    pm_if.dcache_writes       = live_v[3][CTR_W-1:0];
    pm_if.dcache_read_misses  = live_v[4][CTR_W-1:0];
    pm_if.dcache_write_misses = live_v[5][CTR_W-1:0];
    pm_if.dcache_bank_stalls  = live_v[6][CTR_W-1:0];
    pm_if.dcache_mshr_stalls  = live_v[7][CTR_W-1:0];
    pm_if.smem_reads          = live_v[8][CTR_W-1:0];
    pm_if.smem_writes         = live_v[9][CTR_W-1:0];
    pm_if.smem_bank_stalls    = live_v[10][CTR_W-1:0];
    pm_if.mem_reads           = live_v[11][CTR_W-1:0];
    pm_if.mem_writes          = live_v[12][CTR_W-1:0];
    pm_if.mem_latency         = live_v[13][CTR_W-1:0];
    pm_if.same_access         = live_v[14][CTR_W-1:0];
  endtask

  task automatic init_live();
    for (int c = 0; c < NUM_CTRS; c++) live_v[c] = {$urandom, $urandom} & MASK;
    drive_if();
  endtask

  task automatic bump_live(input int max_inc);
    for (int c = 0; c < NUM_CTRS; c++)
      live_v[c] = (live_v[c] + 64'($urandom_range(0, max_inc))) & MASK;
    drive_if();
  endtask

  // Raise snap_valid until accepted; returns one cycle after acceptance.
  task automatic start_snap();
    int g = 0;
    snap_valid = 1'b1;
    while (!snap_ready && g < 100) begin step(); g++; end
    chk("snap_accept_timeout", (g < 100), 1);
    step();
    snap_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < limit) begin step(); g++; end
    chk("drain_timeout", (g < limit), 1);
  endtask

  // Called right after start_snap with rsp_ready high; records the lo/hi words
  // of counter 'want', the beat count, and the beat number carrying rsp_last.
  task automatic capture(input int want, output logic [31:0] lo, output logic [31:0] hi,
                         output int beats, output int last_at);
    int g = 0;
    lo = '0; hi = '0; beats = 0; last_at = 0;
    while (beats < BEATS && g < 200) begin
      if (rsp_valid && rsp_ready) begin
        beats++;
        if (rsp_idx == 4'(want) && !rsp_hi) lo = rsp_data;
        if (rsp_idx == 4'(want) &&  rsp_hi) hi = rsp_data;
        if (rsp_last) last_at = beats;
      end
      step();
      g++;
    end
    chk("capture_timeout", (g < 200), 1);
  endtask

  initial begin
    logic [31:0] lo, hi;
    int          beats, last_at, n, g;
    int          acc [4];
    int          lst [4];
    int          n_acc, n_lst;

    init_live();
    #1 reset = 1'b1;
    #1;
    chk("reset_snap_ready", snap_ready, 0);
    chk("reset_rsp_valid",  rsp_valid,  0);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("post_reset_snap_ready", snap_ready, 1);

    // Directed: icache_reads split into lo/hi words, 30 back-to-back beats.
    live_v[CTR_ICACHE_READS] = 64'h123_4567_89AB;
    drive_if();
    rsp_ready = 1'b1;
    start_snap();
    chk("t1_first_valid", rsp_valid, 1);
    chk("t1_first_data",  rsp_data,  32'h4567_89AB);
    chk("t1_first_idx",   rsp_idx,   0);
    chk("t1_first_hi",    rsp_hi,    0);
    capture(0, lo, hi, beats, last_at);
    chk("t1_lo",      lo,      32'h4567_89AB);
    chk("t1_hi",      hi,      32'h0000_0123);
    chk("t1_beats",   beats,   30);
    chk("t1_last_at", last_at, 30);
    wait_drain(50);

    // Stalls every other cycle while live counters keep moving.
    rsp_ready = 1'b0;
    start_snap();
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      rsp_ready = ~rsp_ready;
      bump_live(1);
      for (int c = 0; c < NUM_CTRS; c++) live_v[c] = (live_v[c] + 64'd1) & MASK;
      drive_if();
      step();
      g++;
    end
    chk("t2_timeout", (g < 200), 1);
    wait_drain(50);

    // snap_valid held high: one acceptance per snapshot, re-accept 1 cycle after last.
    rsp_ready = 1'b1;
    snap_valid = 1'b1;
    n_acc = 0; n_lst = 0;
    for (int t = 0; t < 70; t++) begin
      if (snap_valid && snap_ready && n_acc < 4) begin acc[n_acc] = t; n_acc++; end
      if (rsp_valid && rsp_ready && rsp_last && n_lst < 4) begin lst[n_lst] = t; n_lst++; end
      step();
    end
    snap_valid = 1'b0;
    chk("t3_n_accept", n_acc, 3);
    chk("t3_n_last",   n_lst, 2);
    if (n_acc >= 2 && n_lst >= 1) begin
      chk("t3_accept_spacing", acc[1] - acc[0], 31);
      chk("t3_reaccept_gap",   acc[1] - lst[0], 1);
    end
    wait_drain(50);

    // Reset mid-stream after ten beats.
    rsp_ready = 1'b1;
    start_snap();
    n = 0; g = 0;
    while (n < 10 && g < 100) begin
      if (rsp_valid && rsp_ready) n++;
      if (n < 10) step();
      g++;
    end
    step();
    chk("t4_timeout", (g < 100), 1);
    reset = 1'b1;
    #1;
    chk("t4_rst_rsp_valid",  rsp_valid,  0);
    chk("t4_rst_busy",       busy,       0);
    chk("t4_rst_snap_ready", snap_ready, 0);
    chk("t4_rst_rsp_data",   rsp_data,   0);
    chk("t4_rst_rsp_idx",    rsp_idx,    0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("t4_rel_snap_ready", snap_ready, 1);
    start_snap();
    chk("t4_restart_valid", rsp_valid, 1);
    chk("t4_restart_idx",   rsp_idx,   0);
    chk("t4_restart_hi",    rsp_hi,    0);
    wait_drain(50);

`ifdef PERF_DELTA_EN
    live_v[CTR_MEM_READS] = 64'd100;
    drive_if();
    start_snap();
    capture(int'(CTR_MEM_READS), lo, hi, beats, last_at);
    live_v[CTR_MEM_READS] = 64'd250;
    drive_if();
    start_snap();
    capture(int'(CTR_MEM_READS), lo, hi, beats, last_at);
    chk("t5_delta_lo", lo, 150);
    chk("t5_delta_hi", hi, 0);
    live_v[CTR_MEM_READS] = MASK - 64'd1;
    drive_if();
    start_snap();
    capture(int'(CTR_MEM_READS), lo, hi, beats, last_at);
    live_v[CTR_MEM_READS] = 64'd3;
    drive_if();
    start_snap();
    capture(int'(CTR_MEM_READS), lo, hi, beats, last_at);
    chk("t5_wrap_lo", lo, 5);
    chk("t5_wrap_hi", hi, 0);
`else
    live_v[CTR_MEM_READS] = 64'hABC_1234_5678;
    drive_if();
    start_snap();
    capture(int'(CTR_MEM_READS), lo, hi, beats, last_at);
    chk("t5_abs_lo", lo, 32'h1234_5678);
    chk("t5_abs_hi", hi, 32'h0000_0ABC);
`endif
    wait_drain(50);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 2500; i++) begin
      snap_valid = ($urandom_range(0, 2) == 0);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      bump_live(5);
      step();
    end
    snap_valid = 1'b0;
    rsp_ready  = 1'b1;
    reset      = 1'b0;
    step();
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_memsys_reader.md
PERF_MEMSYS_READER -- requirements
Module: perf_memsys_reader

Interface
REQ-001 SHALL have parameter CTR_W, default 44: width of each memory-system performance counter; legal range 33..64.
REQ-002 SHALL have parameter OUT_W, fixed at 32: width of each streamed data beat.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port perf_memsys_if, input, VX_perf_memsys_if.slave: 15 live counters, each CTR_W bits.
REQ-006 SHALL have port snap_valid, input, 1: snapshot request.
REQ-007 SHALL have port snap_ready, output, 1: snapshot request accepted this cycle.
REQ-008 SHALL have port rsp_valid, output, 1: beat valid.
REQ-009 SHALL have port rsp_ready, input, 1: consumer accepts beat.
REQ-010 SHALL have port rsp_data, output, OUT_W: beat payload.
REQ-011 SHALL have port rsp_idx, output, 4: counter index 0..14, in interface declaration order (icache_reads = 0 ... same_access = 14).
REQ-012 SHALL have port rsp_hi, output, 1: 0 = low word, 1 = high word.
REQ-013 SHALL have port rsp_last, output, 1: final beat of a snapshot.
REQ-014 SHALL have port busy, output, 1: a snapshot is being streamed.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and STREAM.
REQ-016 SHALL drive snap_ready = (state == IDLE).
REQ-017 SHALL, when snap_valid & snap_ready, latch all 15 counters atomically in the same cycle and enter STREAM with beat 0 next.
REQ-018 SHALL assert rsp_valid in the cycle after snapshot acceptance (latency 1) and hold it in STREAM until the last beat is accepted.
REQ-019 SHALL emit 30 beats in the order idx 0 lo, idx 0 hi, idx 1 lo, ..., idx 14 hi.
REQ-020 SHALL form the lo beat from bits [31:0] and the hi beat from bits [CTR_W-1:32], zero-extended to 32 bits.
REQ-021 SHALL advance the beat pointer only on rsp_valid & rsp_ready; payload and sideband SHALL stay stable while rsp_valid & !rsp_ready.
REQ-022 SHALL assert rsp_last only on idx 14 hi.
REQ-023 SHALL return to IDLE in the cycle after the last-beat handshake, so the next snapshot is accepted no earlier than one cycle after rsp_last is accepted.
REQ-024 SHALL ignore live counter changes while in STREAM; the streamed values are those latched at acceptance.
REQ-025 SHALL drive busy = (state == STREAM).

Reset
REQ-026 SHALL, on reset assertion in any state including mid-stream, immediately force IDLE and clear the beat pointer, the snapshot registers and the previous-snapshot registers to 0.
REQ-027 SHALL hold the following output values during reset: rsp_valid = 0, rsp_last = 0, busy = 0, rsp_data = 0, rsp_idx = 0, rsp_hi = 0, snap_ready = 0.
REQ-028 SHALL assert snap_ready from the first cycle after reset deassertion.

Configuration
REQ-029 SHALL use macro PERF_DELTA_EN; when it is defined, each latched value SHALL be (live - previous snapshot) mod 2^CTR_W, and previous SHALL be updated to live at every acceptance.
REQ-030 SHALL, when PERF_DELTA_EN is undefined, stream absolute counter values and instantiate no previous-snapshot registers.

Structure
REQ-031 SHALL place NUM_CTRS = 15, BEATS = 30, the state typedef and the counter-index enum in shared package perf_memsys_pkg.
REQ-032 SHALL be a single module with no sub-module; the beat mux is an internal combinational function.

Verification
REQ-033 Bench SHALL cover: CTR_W = 44, icache_reads = 0x123_4567_89AB, rsp_ready tied 1 -> first beat at acceptance+1 is idx 0 lo 0x456789AB, second beat is idx 0 hi 0x00000123; 30 consecutive beats; rsp_last on beat 30.
REQ-034 Bench SHALL cover: rsp_ready toggling every other cycle, live counters incrementing each cycle -> payload stable across stalls; all values equal those sampled at acceptance.
REQ-035 Bench SHALL cover: snap_valid held high continuously -> snap_ready pulses once per snapshot; second acceptance occurs 1 cycle after the first rsp_last handshake.
REQ-036 Bench SHALL cover: reset asserted after beat 10 -> rsp_valid = 0 immediately; after reset release, snap_ready = 1 and a new snapshot restarts at idx 0 lo.
REQ-037 Bench SHALL cover, with PERF_DELTA_EN defined: snapshot with mem_reads = 100, then snapshot with mem_reads = 250 -> second idx 11 lo = 150; with prev = 2^44-2 and live = 3 -> delta lo = 5, hi = 0.
